multicycle_controller: RTL



---
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control sequencer for the 16-bit datapath: steps each opcode
// through FETCH/DECODE/EXEC/MEM/WB and drives datapath selects and strobes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | wait for Run; latch Inst into IR on exit
// DECODE | classify IR; NOP/illegal retire here, HALT parks
// EXEC   | ALU operation; branches/jumps resolve with IsZero and retire
// MEM    | data-memory access; SW retires here
// WB     | register write-back; R-type/ADDI/LW retire here
// HALT   | parked until reset
module multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Run,
    input  logic [4:0]       Inst,
    input  logic             IsZero,
    output logic             PcEn,
    output logic             PCSrc,
    output logic             RegSrc,
    output logic             RegEn,
    output logic             ALUSrc,
    output logic [3:0]       ALUOp,
    output logic             DmemWr,
    output logic             WrSrc,
    output logic [2:0]       State,
    output logic             Halted,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRet
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [4:0]       ir;
    logic             illegal_q;
    logic [CNT_W-1:0] inst_ret;

    logic op_nop, op_rtype, op_addi, op_lw, op_sw, op_beq, op_bne, op_j;
    logic op_halt, op_illegal, in_instr;

    always_comb begin
        op_nop     = (ir == 5'b00000);
        op_rtype   = (ir >= 5'b00001) && (ir <= 5'b00100);
        op_addi    = (ir == 5'b00101);
        op_lw      = (ir == 5'b00110);
        op_sw      = (ir == 5'b00111);
        op_beq     = (ir == 5'b01000);
        op_bne     = (ir == 5'b01001);
        op_j       = (ir == 5'b01010);
        op_halt    = (ir == 5'b11111);
        op_illegal = (ir > 5'b01010) && !op_halt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= 5'b00000;
        end else if (state == S_FETCH && Run) begin
            ir <= Inst;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (state == S_DECODE && op_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    // Counts retirements (PcEn cycles) and sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_ret <= '0;
        end else if (PcEn && (inst_ret != {CNT_W{1'b1}})) begin
            inst_ret <= inst_ret + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (Run) state_nxt = S_DECODE;
            S_DECODE: begin
                if (op_halt)                      state_nxt = S_HALT;
                else if (op_nop || op_illegal)    state_nxt = S_FETCH;
                else                              state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (op_lw || op_sw)               state_nxt = S_MEM;
                else if (op_rtype || op_addi)     state_nxt = S_WB;
                else                              state_nxt = S_FETCH;
            end
            S_MEM:    state_nxt = op_lw ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Selects are valid for the whole instruction body; strobes only in the
    // retiring or acting state, so an async reset to FETCH kills them at once.
    always_comb begin
        RegSrc   = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 4'b0000;
        WrSrc    = 1'b0;
        PcEn     = 1'b0;
        PCSrc    = 1'b0;
        RegEn    = 1'b0;
        DmemWr   = 1'b0;
        in_instr = (state == S_DECODE) || (state == S_EXEC) ||
                   (state == S_MEM)    || (state == S_WB);

        if (in_instr) begin
            if (op_rtype) begin
                RegSrc = 1'b1;
                WrSrc  = 1'b1;
                ALUOp  = 4'(ir - 5'b00001);
            end
            if (op_addi) begin
                ALUSrc = 1'b1;
                WrSrc  = 1'b1;
            end
            if (op_lw || op_sw) ALUSrc = 1'b1;
            if (op_beq || op_bne) ALUOp = 4'b0001;
        end

        case (state)
            S_DECODE: PcEn = op_nop || op_illegal;
            S_EXEC: begin
                PcEn  = op_beq || op_bne || op_j;
                PCSrc = op_j || (op_beq && IsZero) || (op_bne && !IsZero);
            end
            S_MEM: begin
                PcEn   = op_sw;
                DmemWr = op_sw;
            end
            S_WB: begin
                PcEn  = 1'b1;
                RegEn = 1'b1;
            end
            default: ;
        endcase
    end

    assign State   = state;
    assign Halted  = (state == S_HALT);
    assign Illegal = illegal_q;
    assign InstRet = inst_ret;

endmodule
